// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the single-port synchronous VRAM between the PPU
// renderer (always highest priority), a queue of CPU writes and a single
// pending CPU read. Memory-side outputs are combinational grant decodes, so
// an address driven in cycle N returns data on mem_rdata in cycle N+1.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   render_en/req/addr         renderer request; render_rdata = mem_rdata
//   cpu_wr_valid/addr/data     CPU write push; cpu_wr_ready accepts it
//   cpu_rd_req/addr            CPU read request pulse
//   cpu_rd_busy/valid/data     read status, one-cycle valid, registered data
//   mem_addr/we/wdata/rdata    VRAM port
//   fifo_level, overflow       queued write count, sticky dropped-write flag
module ppu_vram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              render_en,
    input  logic              render_req,
    input  logic [ADDR_W-1:0] render_addr,
    output logic [DATA_W-1:0] render_rdata,
    input  logic              cpu_wr_valid,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_busy,
    output logic              cpu_rd_valid,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    wr_entry_t         fifo_mem [DEPTH];
    wr_entry_t         head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rd_pending;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic              render_grant;
    logic              push;
    logic              pop;
    logic              rd_accept;

    assign render_rdata = mem_rdata;
    assign render_grant = render_en && render_req;
    assign fifo_empty   = (fifo_level == '0);
    assign fifo_full    = (fifo_level == LVL_W'(DEPTH));
    assign head         = fifo_mem[rd_ptr];

    // Writes stall while a read is outstanding to keep read-after-write order.
    assign cpu_wr_ready = !fifo_full && !rd_pending && (state == ST_IDLE);
    assign cpu_rd_busy  = rd_pending || (state != ST_IDLE);
    assign push         = !reset && cpu_wr_valid && cpu_wr_ready;
    assign rd_accept    = !reset && cpu_rd_req && !cpu_rd_busy;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant mux and next state. Reset gates the port so a queued write
    // cannot reach VRAM in the cycle reset is asserted.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        mem_addr  = render_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (reset) begin
            mem_addr  = '0;
            state_nxt = ST_IDLE;
        end else begin
            if (render_grant) begin
                mem_addr = render_addr;
            end else if (!fifo_empty) begin
                pop       = 1'b1;
                mem_addr  = head.addr;
                mem_we    = 1'b1;
                mem_wdata = head.data;
            end else if (rd_pending && (state == ST_IDLE)) begin
                mem_addr  = rd_addr_q;
                state_nxt = ST_RD_WAIT;
            end
            case (state)
                ST_RD_WAIT: state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    ;
            endcase
        end
    end

    // Write queue storage (no reset needed; validity tracked by pointers).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: cpu_wr_addr, data: cpu_wr_data};
        end
    end

    // Queue pointers, level, read slot and read result.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow     <= 1'b0;
            rd_pending   <= 1'b0;
            rd_addr_q    <= '0;
            cpu_rd_valid <= 1'b0;
            cpu_rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
            if (cpu_wr_valid && !cpu_wr_ready) begin
                overflow <= 1'b1;
            end
            if (rd_accept) begin
                rd_pending <= 1'b1;
                rd_addr_q  <= cpu_rd_addr;
            end
            // Data on mem_rdata now belongs to the address issued last cycle.
            if (state == ST_RD_WAIT) begin
                cpu_rd_data <= mem_rdata;
                rd_pending  <= 1'b0;
            end
            cpu_rd_valid <= (state == ST_RD_WAIT);
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Testbench for ppu_vram_arbiter: directed vector table plus hand-written
// sequences for render priority/overflow, read-after-write and mid-drain reset.
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        render_en, render_req;
    logic [15:0] render_addr;
    logic [7:0]  render_rdata;
    logic        cpu_wr_valid;
    logic [15:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ready;
    logic        cpu_rd_req;
    logic [15:0] cpu_rd_addr;
    logic        cpu_rd_busy, cpu_rd_valid;
    logic [7:0]  cpu_rd_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [3:0]  fifo_level;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int we_count = 0;

    logic [7:0] vram [0:65535];

    ppu_vram_arbiter dut (
        .clk(clk), .reset(reset),
        .render_en(render_en), .render_req(render_req), .render_addr(render_addr),
        .render_rdata(render_rdata),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_busy(cpu_rd_busy),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Synchronous single-port VRAM model; also counts write pulses.
    always @(posedge clk) begin
        mem_rdata <= vram[mem_addr];
        if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
            we_count = we_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ren, rreq;
        logic [15:0] raddr;
        logic        wv;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        rq;
        logic [15:0] ra;
        logic        e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_ready, e_busy, e_valid;
        logic [7:0]  e_rdata;
        logic [3:0]  e_level;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(
        input logic ren, input logic rreq, input logic [15:0] raddr,
        input logic wv, input logic [15:0] wa, input logic [7:0] wd,
        input logic rq, input logic [15:0] ra,
        input logic e_we, input logic [15:0] e_addr, input logic [7:0] e_wdata,
        input logic e_ready, input logic e_busy, input logic e_valid,
        input logic [7:0] e_rdata, input logic [3:0] e_level);
        vec_t v;
        v.ren = ren; v.rreq = rreq; v.raddr = raddr;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra;
        v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_ready = e_ready; v.e_busy = e_busy; v.e_valid = e_valid;
        v.e_rdata = e_rdata; v.e_level = e_level;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        render_en = 0; render_req = 0; render_addr = 16'h0000;
        cpu_wr_valid = 0; cpu_wr_addr = 16'h0000; cpu_wr_data = 8'h00;
        cpu_rd_req = 0; cpu_rd_addr = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    int wcyc, vcyc, base;
    logic any_we;

    initial begin
        for (int i = 0; i < 65536; i++) vram[i] = 8'hEE;
        idle_inputs();
        reset = 1;
        tick();

        //      ren rreq raddr    wv wa       wd     rq ra       | we addr     wdata  rdy bsy vld rdata  lvl
        vecs[0]  = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[1]  = mk(0,0,16'h0000, 1,16'h2005,8'hA5, 0,16'h0000, 0,16'h0000,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[2]  = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 1,16'h2005,8'hA5, 1,0,0, 8'h00, 4'd1);
        vecs[3]  = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[4]  = mk(0,1,16'h3F00, 1,16'h2100,8'h11, 0,16'h0000, 0,16'h3F00,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[5]  = mk(0,1,16'h3F00, 0,16'h0000,8'h00, 0,16'h0000, 1,16'h2100,8'h11, 1,0,0, 8'h00, 4'd1);
        vecs[6]  = mk(1,1,16'h0123, 1,16'h2200,8'h22, 0,16'h0000, 0,16'h0123,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[7]  = mk(1,1,16'h0124, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0124,8'h00, 1,0,0, 8'h00, 4'd1);
        vecs[8]  = mk(1,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 1,16'h2200,8'h22, 1,0,0, 8'h00, 4'd1);
        vecs[9]  = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[10] = mk(0,0,16'h0000, 0,16'h0000,8'h00, 1,16'h2005, 0,16'h0000,8'h00, 1,0,0, 8'h00, 4'd0);
        vecs[11] = mk(0,0,16'h0000, 0,16'h0000,8'h00, 1,16'h2100, 0,16'h2005,8'h00, 0,1,0, 8'h00, 4'd0);
        vecs[12] = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 0,1,0, 8'h00, 4'd0);
        vecs[13] = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 0,1,1, 8'hA5, 4'd0);
        vecs[14] = mk(0,0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 1,0,0, 8'hA5, 4'd0);
        vecs[15] = mk(0,0,16'h0000, 1,16'h2006,8'h5A, 0,16'h0000, 0,16'h0000,8'h00, 1,0,0, 8'hA5, 4'd0);

        // Reset state, sampled while reset is still held.
        #2;
        chk("rst_mem_we", 0, mem_we, 0);
        chk("rst_mem_addr", 0, mem_addr, 0);
        tick();
        reset = 0;

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            render_en = vecs[i].ren; render_req = vecs[i].rreq; render_addr = vecs[i].raddr;
            cpu_wr_valid = vecs[i].wv; cpu_wr_addr = vecs[i].wa; cpu_wr_data = vecs[i].wd;
            cpu_rd_req = vecs[i].rq; cpu_rd_addr = vecs[i].ra;
            #2;
            chk("v_mem_we", i, mem_we, vecs[i].e_we);
            chk("v_mem_addr", i, mem_addr, vecs[i].e_addr);
            chk("v_mem_wdata", i, mem_wdata, vecs[i].e_wdata);
            chk("v_wr_ready", i, cpu_wr_ready, vecs[i].e_ready);
            chk("v_rd_busy", i, cpu_rd_busy, vecs[i].e_busy);
            chk("v_rd_valid", i, cpu_rd_valid, vecs[i].e_valid);
            chk("v_rd_data", i, cpu_rd_data, vecs[i].e_rdata);
            chk("v_fifo_level", i, fifo_level, vecs[i].e_level);
            chk("v_overflow", i, overflow, 0);
            tick();
        end

        // Render priority: fill the queue under render, overflow, then drain.
        do_reset();
        any_we = 0;
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            render_en = 1; render_req = 1; render_addr = 16'h0100 + 16'(c);
            if (c <= 8) begin
                cpu_wr_valid = 1; cpu_wr_addr = 16'h2400 + 16'(c); cpu_wr_data = 8'h40 + 8'(c);
            end
            #2;
            if (mem_we) any_we = 1;
            if (c == 8) begin
                chk("rp_level_full", c, fifo_level, 8);
                chk("rp_ready_full", c, cpu_wr_ready, 0);
                chk("rp_ovf_before", c, overflow, 0);
            end
            if (c == 9) chk("rp_ovf_after", c, overflow, 1);
            tick();
        end
        chk("rp_no_we_in_render", 0, any_we, 0);
        idle_inputs();
        for (int d = 0; d < 8; d++) begin
            #2;
            chk("rp_drain_we", d, mem_we, 1);
            chk("rp_drain_addr", d, mem_addr, 16'h2400 + 16'(d));
            chk("rp_drain_data", d, mem_wdata, 8'h40 + 8'(d));
            tick();
        end
        #2;
        chk("rp_after_we", 0, mem_we, 0);
        chk("rp_after_level", 0, fifo_level, 0);
        chk("rp_ovf_sticky", 0, overflow, 1);
        tick();

        // Read-after-write in the same cycle.
        do_reset();
        cpu_wr_valid = 1; cpu_wr_addr = 16'h23C0; cpu_wr_data = 8'h3C;
        cpu_rd_req = 1; cpu_rd_addr = 16'h23C0;
        tick();
        idle_inputs();
        wcyc = -1; vcyc = -1;
        for (int cyc = 1; cyc < 12; cyc++) begin
            #2;
            if (mem_we && mem_addr == 16'h23C0 && wcyc < 0) wcyc = cyc;
            if (cpu_rd_valid && vcyc < 0) vcyc = cyc;
            tick();
        end
        chk("raw_write_cycle", 0, wcyc, 1);
        chk("raw_valid_cycle", 0, vcyc, 4);
        chk("raw_rd_data", 0, cpu_rd_data, 8'h3C);

        // Reset mid-drain with a pending read and an overflow outstanding.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            render_en = 1; render_req = 1;
            cpu_wr_valid = 1; cpu_wr_addr = 16'h2500 + 16'(c); cpu_wr_data = 8'h50 + 8'(c);
            tick();
        end
        idle_inputs();
        base = we_count;
        cpu_rd_req = 1; cpu_rd_addr = 16'h2500;
        #2;
        chk("rm_level5", 0, fifo_level, 5);
        chk("rm_we_c5", 0, mem_we, 1);
        tick();
        idle_inputs();
        cpu_wr_valid = 1; cpu_wr_addr = 16'h2600; cpu_wr_data = 8'h66;
        #2;
        chk("rm_we_c6", 0, mem_we, 1);
        chk("rm_ready_c6", 0, cpu_wr_ready, 0);
        tick();
        idle_inputs();
        reset = 1;
        #2;
        chk("rm_ovf_pre", 0, overflow, 1);
        chk("rm_we_in_reset", 0, mem_we, 0);
        tick();
        reset = 0;
        #2;
        chk("rm_we", 0, mem_we, 0);
        chk("rm_addr", 0, mem_addr, 0);
        chk("rm_wdata", 0, mem_wdata, 0);
        chk("rm_ready", 0, cpu_wr_ready, 1);
        chk("rm_busy", 0, cpu_rd_busy, 0);
        chk("rm_valid", 0, cpu_rd_valid, 0);
        chk("rm_rdata", 0, cpu_rd_data, 0);
        chk("rm_level", 0, fifo_level, 0);
        chk("rm_ovf", 0, overflow, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            #2;
            chk("rm_idle_busy", c, cpu_rd_busy, 0);
        end
        chk("rm_we_pulses", 0, we_count - base, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
